// File: rtl/timer_pkg.sv
// Shared definitions for the tick-driven timers in the Morse game timing chain.
// Terminal constants assume a 100 ms upstream tick.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } timer_state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  localparam int TERM_500MS = 5;
  localparam int TERM_1S    = 10;
  localparam int TERM_5S    = 50;
  localparam int TERM_10S   = 100;

endpackage

// File: rtl/tick_timeout_timer.sv
// Tick-counting timeout timer: counts prescaler ticks while running and
// pulses timeout after a terminal count latched at start. One-shot mode
// parks in DONE with done held high; periodic mode wraps and keeps running.
module tick_timeout_timer
  import timer_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int DEF_TERM = TERM_5S
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_in,
  input  logic             start,
  input  logic             pause,
  input  logic             clear,
  input  logic [CNT_W-1:0] term_in,
  input  logic             mode_in,
  output logic             timeout,
  output logic             done,
  output logic             busy,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] DEF_TERM_V = CNT_W'(DEF_TERM);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO       = '0;

  timer_state_t     state;
  logic [CNT_W-1:0] term_q;
  logic             mode_q;

  // Control state, counter and all outputs; clear beats start beats pause beats tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      count   <= ZERO;
      term_q  <= DEF_TERM_V;
      mode_q  <= MODE_ONESHOT;
      timeout <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (clear) begin
        state <= IDLE;
        count <= ZERO;
        done  <= 1'b0;
        busy  <= 1'b0;
      end else if (start) begin
        state  <= RUN;
        count  <= ZERO;
        term_q <= (term_in == ZERO) ? DEF_TERM_V : term_in;
        mode_q <= mode_in;
        done   <= 1'b0;
        busy   <= 1'b1;
      end else begin
        case (state)
          RUN: begin
            if (pause) begin
              state <= PAUSE;
            end else if (tick_in) begin
              if (count == term_q - ONE) begin
                count   <= ZERO;
                timeout <= 1'b1;
                if (mode_q == MODE_ONESHOT) begin
                  state <= DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                end
              end else begin
                count <= count + ONE;
              end
            end
          end
          PAUSE: begin
            if (!pause) begin
              state <= RUN;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tick_timeout_timer.sv
// Scoreboard bench for tick_timeout_timer: a driver applies one stimulus
// vector per cycle and pushes the reference model's expected outputs; a
// monitor pops and compares after every rising edge.
module tb_tick_timeout_timer;

  localparam int CNT_W    = 8;
  localparam int DEF_TERM = 50;

  logic             clk = 1'b0;
  logic             rst;
  logic             tick_in;
  logic             start;
  logic             pause;
  logic             clear;
  logic [CNT_W-1:0] term_in;
  logic             mode_in;
  logic             timeout;
  logic             done;
  logic             busy;
  logic [CNT_W-1:0] count;

  typedef struct {
    logic             timeout;
    logic             done;
    logic             busy;
    logic [CNT_W-1:0] count;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  // Held inputs between cycles
  logic             cur_rst   = 1'b0;
  logic             cur_pause = 1'b0;
  logic [CNT_W-1:0] cur_term  = '0;
  logic             cur_mode  = 1'b0;

  // Reference model, described in terms of the timer's behaviour
  bit m_active;
  bit m_paused;
  bit m_done;
  bit m_periodic;
  int m_count;
  int m_term;

  tick_timeout_timer #(.CNT_W(CNT_W), .DEF_TERM(DEF_TERM)) dut (
    .clk    (clk),
    .rst    (rst),
    .tick_in(tick_in),
    .start  (start),
    .pause  (pause),
    .clear  (clear),
    .term_in(term_in),
    .mode_in(mode_in),
    .timeout(timeout),
    .done   (done),
    .busy   (busy),
    .count  (count)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_active   = 0;
    m_paused   = 0;
    m_done     = 0;
    m_periodic = 0;
    m_count    = 0;
    m_term     = DEF_TERM;
  endtask

  // One cycle: drive inputs at the falling edge, predict the next edge, push it
  task automatic apply_stimulus(input bit t, input bit s, input bit c);
    exp_t e;
    bit   to;
    @(negedge clk);
    rst     = cur_rst;
    tick_in = t;
    start   = s;
    clear   = c;
    pause   = cur_pause;
    term_in = cur_term;
    mode_in = cur_mode;
    to = 0;
    if (!cur_rst) begin
      model_reset();
    end else if (c) begin
      m_active = 0;
      m_paused = 0;
      m_done   = 0;
      m_count  = 0;
    end else if (s) begin
      m_term     = (cur_term == 0) ? DEF_TERM : int'(cur_term);
      m_periodic = cur_mode;
      m_count    = 0;
      m_done     = 0;
      m_active   = 1;
      m_paused   = 0;
    end else if (m_active && m_paused) begin
      m_paused = cur_pause;
    end else if (m_active) begin
      if (cur_pause) begin
        m_paused = 1;
      end else if (t) begin
        if (m_count + 1 == m_term) begin
          m_count = 0;
          to = 1;
          if (!m_periodic) begin
            m_active = 0;
            m_done   = 1;
          end
        end else begin
          m_count = m_count + 1;
        end
      end
    end
    e.timeout = to;
    e.done    = m_done;
    e.busy    = m_active;
    e.count   = CNT_W'(m_count);
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(0, 0, 0);
  endtask

  task automatic tick_spaced(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      apply_stimulus(1, 0, 0);
      idle(gap);
    end
  endtask

  task automatic do_start(input int term, input bit mode);
    cur_term = CNT_W'(term);
    cur_mode = mode;
    apply_stimulus(0, 1, 0);
  endtask

  // Asynchronous reset between edges; outputs must drop without a clock
  task automatic async_reset();
    @(posedge clk);
    #3;
    rst     = 1'b0;
    cur_rst = 1'b0;
    #1;
    check_output("async_rst_timeout", int'(timeout), 0);
    check_output("async_rst_done", int'(done), 0);
    check_output("async_rst_busy", int'(busy), 0);
    check_output("async_rst_count", int'(count), 0);
  endtask

  // Monitor: every rising edge the DUT presents new outputs; compare to scoreboard
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_output("timeout", int'(timeout), int'(e.timeout));
        check_output("done", int'(done), int'(e.done));
        check_output("busy", int'(busy), int'(e.busy));
        check_output("count", int'(count), int'(e.count));
      end
    end
  end

  // Driver: directed scenarios then randomized traffic
  initial begin
    rst = 1'b0; tick_in = 0; start = 0; pause = 0; clear = 0;
    term_in = '0; mode_in = 0;
    model_reset();

    idle(3);
    cur_rst = 1'b1;
    idle(2);

    // Reset in the middle of a count, ticks ignored afterwards
    do_start(5, 0);
    tick_spaced(3, 1);
    async_reset();
    idle(2);
    cur_rst = 1'b1;
    tick_spaced(3, 1);

    // One-shot expiry and post-expiry ticks
    do_start(5, 0);
    tick_spaced(5, 9);
    tick_spaced(3, 2);

    // Periodic with pause
    do_start(3, 1);
    tick_spaced(9, 2);
    cur_pause = 1'b1;
    idle(1);
    tick_spaced(2, 1);
    cur_pause = 1'b0;
    idle(1);
    tick_spaced(4, 1);
    apply_stimulus(0, 0, 1);

    // Default terminal via term_in = 0, back-to-back ticks
    do_start(0, 0);
    for (int i = 0; i < 52; i++) apply_stimulus(1, 0, 0);
    idle(2);

    // start with coincident tick is not counted
    cur_term = 4; cur_mode = 0;
    apply_stimulus(1, 1, 0);
    idle(1);
    // clear on the terminal tick
    do_start(2, 0);
    apply_stimulus(1, 0, 0);
    apply_stimulus(1, 0, 1);
    idle(2);
    // restart out of DONE
    do_start(3, 0);
    tick_spaced(3, 1);
    do_start(2, 0);
    tick_spaced(2, 1);

    // Back-to-back expiry with term 4
    do_start(4, 1);
    for (int i = 0; i < 4; i++) apply_stimulus(1, 0, 0);
    idle(3);

    // Randomized traffic, with term/mode wiggling mid-run
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(99, 0);
      cur_term = CNT_W'($urandom_range(6, 0));
      cur_mode = 1'($urandom_range(1, 0));
      if ($urandom_range(19, 0) == 0) cur_pause = ~cur_pause;
      apply_stimulus($urandom_range(9, 0) < 5, (r >= 2 && r < 6), (r == 7));
    end
    cur_pause = 1'b0;
    idle(3);

    @(posedge clk);
    #2;
    check_output("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
